// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - shares one 32-bit carry-skip adder among NREQ requesters (ADDARB_ROUND_ROBIN_EN selects round-robin)

module carry_skip_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    // Eight 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight through
    always_comb begin
        logic c;
        logic bc;
        logic p;
        logic all_p;
        sum   = '0;
        c     = cin;
        for (int blk = 0; blk < 8; blk++) begin
            bc    = c;
            all_p = 1'b1;
            for (int i = 0; i < 4; i++) begin
                p                = a[blk*4+i] ^ b[blk*4+i];
                sum[blk*4+i]     = p ^ bc;
                bc               = (a[blk*4+i] & b[blk*4+i]) | (p & bc);
                all_p            = all_p & p;
            end
            c = all_p ? c : bc;
        end
        cout = c;
    end
endmodule

module adder_share_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*32-1:0]         req_a,
    input  logic [NREQ*32-1:0]         req_b,
    input  logic [NREQ-1:0]            req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [31:0]                rsp_sum,
    output logic                       rsp_cout,
    output logic                       busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic           cin_q, cin_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic [31:0]    add_sum;
    logic           add_cout;
`ifdef ADDARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q, ptr_d;
`endif

    carry_skip_adder_32bit u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Pick the requester to serve next from the current valid vector
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
`ifdef ADDARB_ROUND_ROBIN_EN
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(k);
            end
        end
`endif
    end

    // Accept strobe only in IDLE and never while reset is held
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == S_IDLE) && grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state, operand capture and result capture
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        id_d       = id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
`ifdef ADDARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    a_d     = req_a[{grant_idx, 5'd0} +: 32];
                    b_d     = req_b[{grant_idx, 5'd0} +: 32];
                    cin_d   = req_cin[grant_idx];
                    id_d    = grant_idx;
                    state_d = S_CALC;
`ifdef ADDARB_ROUND_ROBIN_EN
                    ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
                end
            end
            S_CALC: begin
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_id_d   = id_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
`ifdef ADDARB_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            id_q       <= id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
`ifdef ADDARB_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter (honours ADDARB_ROUND_ROBIN_EN)

module tb_adder_share_arbiter;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_cout;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // transaction-level model: phase 0 waiting, 1 computing, 2 presenting
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    logic [32:0] m_res   = '0;
    logic [31:0] e_sum   = '0;
    logic        e_cout  = 1'b0;
    int          e_id    = 0;
    logic [NREQ-1:0] last_ready = '0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
`ifdef ADDARB_ROUND_ROBIN_EN
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    // model advance on each active edge
    initial begin
        int g;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0; m_ptr = 0; e_sum = '0; e_cout = 1'b0; e_id = 0;
            end else if (m_phase == 0) begin
                g = model_grant(req_valid, m_ptr);
                if (g >= 0) begin
                    m_id    = g;
                    m_res   = {1'b0, req_a[g*32 +: 32]} + {1'b0, req_b[g*32 +: 32]} + 33'(req_cin[g]);
                    m_ptr   = (g + 1) % NREQ;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                e_sum   = m_res[31:0];
                e_cout  = m_res[32];
                e_id    = m_id;
                m_phase = 2;
            end else if (rsp_ready) begin
                m_phase = 0;
            end
        end
    end

    // compare every cycle on the falling edge
    initial begin
        int g;
        logic [NREQ-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            last_ready = req_ready;
            if (!rst_n) begin
                check("rst_req_ready", 64'(req_ready), 64'd0);
                check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
                check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
                check("rst_rsp_id", 64'(rsp_id), 64'd0);
            end else begin
                g = model_grant(req_valid, m_ptr);
                exp_rdy = '0;
                if (m_phase == 0 && g >= 0) exp_rdy[g] = 1'b1;
                check("req_ready", 64'(req_ready), 64'(exp_rdy));
                check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
                check("busy", 64'(busy), 64'(m_phase != 0));
                check("rsp_sum", 64'(rsp_sum), 64'(e_sum));
                check("rsp_cout", 64'(rsp_cout), 64'(e_cout));
                check("rsp_id", 64'(rsp_id), 64'(e_id));
            end
        end
    end

    // drive the same operands on every requester in mask, expect requester xid to win
    task automatic do_txn(input logic [NREQ-1:0] mask, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] xs, input logic xc, input int xid);
        bit acc;
        int lat;
        @(posedge clk); #1;
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = a;
            req_b[i*32 +: 32] = b;
            req_cin[i]        = cin;
        end
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            if (req_ready[xid]) acc = 1'b1;
        end
        check("txn_accept", 64'(acc), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (rsp_valid) lat = n;
        end
        check("txn_latency", 64'(lat), 64'd2);
        check("txn_sum", 64'(rsp_sum), 64'(xs));
        check("txn_cout", 64'(rsp_cout), 64'(xc));
        check("txn_id", 64'(rsp_id), 64'(xid));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cap_sum;
        logic        cap_cout;
        logic [1:0]  cap_id;
        int          seen;
        int          exp_id;

        // reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(req_ready), 64'd0);
            check("idle_valid", 64'(rsp_valid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_sum", 64'(rsp_sum), 64'd0);
        end

        // single request and carry cases
        do_txn(4'b0010, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1);
        do_txn(4'b0100, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 2);
        do_txn(4'b1000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 3);
        do_txn(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 0);
        do_txn(4'b0001, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 0);

        // backpressure
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'h100 * (i + 1);
            req_b[i*32 +: 32] = 32'h7;
            req_cin[i]        = 1'b0;
        end
        seen = 0;
        for (int t = 0; t < 10 && seen == 0; t++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("bp_reach_resp", 64'(seen), 64'd1);
        cap_sum = rsp_sum; cap_cout = rsp_cout; cap_id = rsp_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_sum", 64'(rsp_sum), 64'(cap_sum));
            check("bp_hold_cout", 64'(rsp_cout), 64'(cap_cout));
            check("bp_hold_id", 64'(rsp_id), 64'(cap_id));
            check("bp_no_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("bp_next_grant", 64'(req_ready != '0), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // arbitration with all requesters continuously valid
        pulse_reset();
        @(posedge clk); #1;
        req_valid = '1;
        seen = 0;
        for (int t = 0; t < 100 && seen < 12; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
`ifdef ADDARB_ROUND_ROBIN_EN
                exp_id = seen % NREQ;
`else
                exp_id = 0;
`endif
                check("arb_id", 64'(rsp_id), 64'(exp_id));
                seen++;
            end
        end
        check("arb_count", 64'(seen), 64'd12);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // reset during CALC
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_a[32 +: 32] = 32'h5; req_b[32 +: 32] = 32'h6; req_cin[1] = 1'b0;
        seen = 0;
        for (int t = 0; t < 10 && seen == 0; t++) begin
            @(negedge clk);
            if (req_ready[1]) seen = 1;
        end
        check("rm_accept", 64'(seen), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rm_no_rsp", 64'(rsp_valid), 64'd0);
        end
        do_txn(4'b1010, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 1);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++) begin
                if (last_ready[i] || !req_valid[i]) begin
                    req_valid[i]      = ($urandom % 3) == 0;
                    req_a[i*32 +: 32] = (($urandom % 8) == 0) ? 32'hFFFFFFFF : 32'($urandom);
                    req_b[i*32 +: 32] = (($urandom % 8) == 0) ? 32'hFFFFFFFF : 32'($urandom);
                    req_cin[i]        = 1'($urandom);
                end else if (($urandom % 10) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Shares one `carry_skip_adder_32bit` instance between `NREQ` requesters. Each requester presents operands over a valid/ready handshake. The arbiter grants one requester, sequences the operands through the adder and returns a registered sum, carry-out and requester ID over a response handshake. It sits between the client units and the shared 32-bit adder datapath; the adder is instantiated inside this block.

## Interface
- `NREQ`, default 4: number of requesters (2..8). The operand width is fixed at 32 bits by the adder.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept strobe; one-hot or zero.
- `req_a`  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  NREQ*32  operand B; same packing as `req_a`.
- `req_cin`  in  NREQ  carry-in per requester.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accepts result.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the result.
- `rsp_sum`  out  32  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `busy`  out  1  high in CALC and RESP.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE**
  - When any `req_valid` is high, the arbiter selects grant g.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - `a`, `b`, `cin` and `id` are latched into operand registers.
  - Next state is CALC.
  - With no valid request, the FSM stays in IDLE and `req_ready` is 0.
- **CALC**
  - The latched operands drive the adder.
  - At the end of the cycle, the adder sum and carry-out are captured into `rsp_sum`/`rsp_cout`, and `rsp_id` is set to the latched id.
  - Next state is RESP.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_ready` = 1, the response completes and the FSM returns to IDLE.
  - Otherwise the FSM holds in RESP with all `rsp_*` outputs stable.
- **Arithmetic:** `{rsp_cout, rsp_sum}` = a + b + cin, 33-bit unsigned. No overflow flag.
- **Requester protocol:** `req_valid`, `req_a`, `req_b` and `req_cin` must hold until `req_ready` for that requester. Deasserting `req_valid` before it is granted withdraws the request and is legal.
- **Busy behaviour:** no request is accepted while the FSM is in CALC or RESP; `req_ready` is all zeros there.
- **Reset mid-operation:** the in-flight transaction is dropped and no response is produced. The round-robin pointer returns to 0.
- **Reset values:**
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0, `busy` = 0.
  - `req_ready` = 0 while `rst_n` is low.
  - Operand registers = 0, priority pointer = 0.

## Timing
- A request is accepted in cycle T (`req_valid[g]` && `req_ready[g]`).
- `rsp_valid` rises at the clock edge ending cycle T+1, so it is visible in cycle T+2.
- Minimum latency is 2 cycles.
- The earliest next accept is cycle T+3, provided `rsp_ready` is high in T+2. Peak throughput is one operation per 3 cycles.
- When `rsp_ready` is low, the FSM stalls in RESP indefinitely; there is no timeout.
- The adder path, latched operands to sum/cout registers, must close within one `clk` period. The adder is the critical path.
- `req_ready` depends combinationally on `req_valid` and state. No combinational path exists from `rsp_ready` to `req_ready`.

## Configuration
- Macro: `ADDARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - The search starts at pointer p and wraps modulo NREQ.
  - After each grant g, p becomes (g+1) mod NREQ.
  - With all requesters continuously valid, grants are fair: 0, 1, …, NREQ-1, 0, …
- **Undefined:** fixed priority. The lowest index wins, the pointer logic is omitted, and higher-index requesters can starve.

## Test plan
- **Reset and idle:** assert `rst_n`=0, then release with no requests → all outputs 0 and `req_ready`=0 for 20 cycles.
- **Single request and latency:** requester 1 sends `0000FFFF` + `00000001`, cin 0 → `req_ready[1]` high in cycle T; `rsp_valid` high in T+2 with `rsp_id`=1, `rsp_sum`=`00010000`, `rsp_cout`=0.
- **Carry cases:**
  - `AAAAAAAA` + `55555555`, cin 1 → sum `00000000`, cout 1.
  - `FFFFFFFF` + `00000001`, cin 0 → sum `00000000`, cout 1.
  - `FFFFFFFF` + `FFFFFFFF`, cin 1 → sum `FFFFFFFF`, cout 1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready`=0 despite pending requests; one cycle after `rsp_ready`=1, the next grant occurs.
- **Arbitration:** all 4 requesters continuously valid for 12 transactions.
  - With `ADDARB_ROUND_ROBIN_EN`, `rsp_id` sequence is 0,1,2,3,0,1,2,3,…
  - Without it, all grants go to 0.
- **Reset mid-operation:** pulse `rst_n` low during CALC → no `rsp_valid`; the next request gets a correct result, and under round-robin the pointer restarts at 0.
